// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, instruction class and
// the register-operand usage helper used by the load-use interlock.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    CLS_R = 2'b00,
    CLS_I = 2'b01,
    CLS_J = 2'b10
  } ins_class_t;

  // Opcodes that read rt as a source operand.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-execute bundle around the decode stage: input handshake with the
// raw instruction, output handshake with the decoded fields.
interface id_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ins;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_op;
  logic [5:0]      out_funct;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [XLEN-1:0] out_imm;
  logic [PC_W-1:0] out_jtarget;
  logic [1:0]      out_class;
  logic [PC_W-1:0] out_pc;

  modport slave (
    input  in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_funct, out_rs, out_rt, out_rd,
           out_shamt, out_imm, out_jtarget, out_class, out_pc
  );

  modport master (
    output in_valid, in_ins, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_funct, out_rs, out_rt, out_rd,
           out_shamt, out_imm, out_jtarget, out_class, out_pc
  );
endinterface

// File: rtl/ins_fields.sv
// Combinational instruction slicer: field extraction, immediate extension,
// class decode and jump-target formation.
module ins_fields
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic [31:0]     ins,
  input  logic [PC_W-1:0] pc,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [XLEN-1:0] imm,
  output logic [PC_W-1:0] jtarget,
  output ins_class_t      cls,
  output logic            uses_rt,
  output logic            is_lw
);

  logic signed [15:0] imm16;
  logic [PC_W-1:0]    pc_plus4;

  assign op     = ins[31:26];
  assign rs     = ins[25:21];
  assign rt     = ins[20:16];
  assign rd     = ins[15:11];
  assign shamt  = ins[10:6];
  assign funct  = ins[5:0];
  assign imm16  = $signed(ins[15:0]);

  assign uses_rt = op_uses_rt(op);
  assign is_lw   = (op == OP_LW);

  always_comb begin
    imm = XLEN'(imm16);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm = XLEN'(ins[15:0]);
      OP_LUI:                   imm = XLEN'({ins[15:0], 16'h0000});
      default:                  imm = XLEN'(imm16);
    endcase
  end

  always_comb begin
    cls = CLS_I;
    case (op)
      OP_RTYPE:    cls = CLS_R;
      OP_J, OP_JAL: cls = CLS_J;
      default:     cls = CLS_I;
    endcase
  end

  assign pc_plus4 = pc + PC_W'(4);

  // Region bits come from the sequential PC, not the PC of the jump itself.
  generate
    if (PC_W > 28) begin : g_region
      assign jtarget = {pc_plus4[PC_W-1:28], ins[25:0], 2'b00};
    end else begin : g_noregion
      assign jtarget = {ins[25:0], 2'b00};
    end
  endgenerate

endmodule

// File: rtl/id_stage.sv
// Registered decode stage with valid/ready handshake, flush, and a one-bubble
// load-use interlock that counts the bubbles it inserts.
module id_stage
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  id_stage_if.slave   bus,
  output logic [15:0] stall_cnt
);

  logic [5:0]      d_op, d_funct;
  logic [4:0]      d_rs, d_rt, d_rd, d_shamt;
  logic [XLEN-1:0] d_imm;
  logic [PC_W-1:0] d_jtarget;
  ins_class_t      d_cls;
  logic            d_uses_rt, d_is_lw;

  logic            vld_p0;
  logic [5:0]      op_p0, funct_p0;
  logic [4:0]      rs_p0, rt_p0, rd_p0, shamt_p0;
  logic [XLEN-1:0] imm_p0;
  logic [PC_W-1:0] jtarget_p0, pc_p0;
  ins_class_t      cls_p0;

  logic            ld_flag;
  logic [4:0]      ld_rt;
  logic            slot_free, hazard, accept, ld_set;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  ins_fields #(.XLEN(XLEN), .PC_W(PC_W)) u_fields (
    .ins     (bus.in_ins),
    .pc      (bus.in_pc),
    .op      (d_op),
    .funct   (d_funct),
    .rs      (d_rs),
    .rt      (d_rt),
    .rd      (d_rd),
    .shamt   (d_shamt),
    .imm     (d_imm),
    .jtarget (d_jtarget),
    .cls     (d_cls),
    .uses_rt (d_uses_rt),
    .is_lw   (d_is_lw)
  );

  assign slot_free = !vld_p0 || bus.out_ready;
  assign hazard    = bus.in_valid && ld_flag &&
                     ((d_rs == ld_rt) || (d_uses_rt && (d_rt == ld_rt)));
  assign bus.in_ready = slot_free && !hazard && !flush;
  assign accept    = bus.in_valid && bus.in_ready;
  assign ld_set    = d_is_lw && (d_rt != 5'd0);

  // ---- stage p0: control (valid, interlock tracking, bubble counter) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      ld_flag   <= 1'b0;
      ld_rt     <= 5'd0;
      stall_cnt <= 16'd0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      ld_flag <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      ld_flag <= ld_set;
      if (ld_set) ld_rt <= d_rt;
    end else begin
      if (bus.out_ready) vld_p0 <= 1'b0;
      if (hazard && slot_free) begin
        ld_flag   <= 1'b0;
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  // ---- stage p0: decoded fields, captured only on acceptance ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0      <= '0;
      funct_p0   <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      rd_p0      <= '0;
      shamt_p0   <= '0;
      imm_p0     <= '0;
      jtarget_p0 <= '0;
      pc_p0      <= '0;
      cls_p0     <= CLS_R;
    end else if (accept) begin
      op_p0      <= d_op;
      funct_p0   <= d_funct;
      rs_p0      <= d_rs;
      rt_p0      <= d_rt;
      rd_p0      <= d_rd;
      shamt_p0   <= d_shamt;
      imm_p0     <= d_imm;
      jtarget_p0 <= d_jtarget;
      pc_p0      <= bus.in_pc;
      cls_p0     <= d_cls;
    end
  end

  assign bus.out_valid   = vld_p0;
  assign bus.out_op      = op_p0;
  assign bus.out_funct   = funct_p0;
  assign bus.out_rs      = rs_p0;
  assign bus.out_rt      = rt_p0;
  assign bus.out_rd      = rd_p0;
  assign bus.out_shamt   = shamt_p0;
  assign bus.out_imm     = imm_p0;
  assign bus.out_jtarget = jtarget_p0;
  assign bus.out_class   = cls_p0;
  assign bus.out_pc      = pc_p0;

endmodule

// File: doc/id_stage.md
# id_stage

Registered instruction-decode pipeline stage for the MIPS core. It sits between fetch and execute, slices the 32-bit instruction into its fields, and adds registered outputs with a valid/ready handshake. It also extends the immediate according to opcode, classifies the instruction, computes the jump target, and enforces a one-bubble load-use interlock. Flush support covers branch redirect.

## Interface
- `XLEN`, 32, width of the extended immediate; must be ≥ 32.
- `PC_W`, 32, PC width; must be ≥ 28.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_ins`  in  32  instruction word
- `in_pc`  in  PC_W  address of `in_ins`
- `flush`  in  1  synchronous kill of stage contents
- `out_valid`  out  1  decoded instruction held
- `out_ready`  in  1  execute consumes it
- `out_op`, `out_funct`  out  6  fields [31:26], [5:0]
- `out_rs`, `out_rt`, `out_rd`, `out_shamt`  out  5  fields [25:21], [20:16], [15:11], [10:6]
- `out_imm`  out  XLEN  extended immediate
- `out_jtarget`  out  PC_W  jump target
- `out_class`  out  2  00 R, 01 I, 10 J
- `out_pc`  out  PC_W  PC of held instruction
- `stall_cnt`  out  16  saturating count of interlock bubbles

## Operation
- Instruction is accepted when `in_valid && in_ready`. On acceptance, all `out_*` fields are registered from `in_ins`/`in_pc` and `out_valid` is set to 1.
- Slot free: `slot_free = !out_valid || out_ready`.
- Ready: `in_ready = slot_free && !hazard && !flush`.
- If `out_ready` is high and no new acceptance occurs, `out_valid` goes to 0.
- Immediate extension:
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extend.
  - LUI 0x0F: `{imm, 16'b0}`, then zero-extended to XLEN.
  - All other opcodes: sign-extend.
- Class: op 0x00 is R; op 0x02/0x03 is J; everything else is I.
- Jump target: `{(in_pc+4)[PC_W-1:28], ins[25:0], 2'b00}`. It is computed for every instruction and meaningful only for class J.
- Load tracking:
  - On acceptance of LW (0x23) with rt ≠ 0: set `ld_flag`, capture `ld_rt`.
  - On acceptance of any other instruction: clear `ld_flag`.
- Hazard: `in_valid && ld_flag && (rs == ld_rt || (uses_rt && rt == ld_rt))`, where `uses_rt` is op ∈ {0x00, 0x2B, 0x04, 0x05}.
- Hazard with `slot_free`:
  - No acceptance; `out_valid` follows the consume rule (bubble).
  - `ld_flag` clears.
  - `stall_cnt` increments, saturating at 0xFFFF.
  - The next cycle accepts normally.
- Hazard without `slot_free`: hold; `ld_flag` is unchanged and there is no count.
- `flush` has highest priority: `out_valid` ← 0, `ld_flag` ← 0, no acceptance. Held field values are don't-care afterwards.

## Timing
- Latency 1 cycle, acceptance edge to `out_valid`. Throughput 1 per cycle when there is no hazard.
- `in_ready` is combinational from `out_ready`, `out_valid`, `flush`, `in_*` and `ld_*`. This is a documented comb path.
- Output fields stay stable while `out_valid && !out_ready`.
- Reset (asynchronous, any time, including mid-stall): `out_valid`, every `out_*` field, `ld_flag`, `ld_rt` and `stall_cnt` all go to 0. The first acceptance is possible on the first edge after `rst` deasserts.
- Load-use costs exactly one bubble, in the cycle the dependent instruction is first presented with `slot_free`.
- `flush` together with `in_valid`: the input is not accepted, and fetch must re-present it or drop it.

## Structure
- Shared package `mips_pkg`:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI, OP_LUI;
  - `ins_class_t` enum (R/I/J).
- Sub-module `ins_fields`: purely combinational slicer plus extender/classifier on `in_ins`. `id_stage` holds the registers, handshake and interlock.

## Test plan
- Reset then stream: ADDI 0x2001FFFF then ORI 0x3422FFFF, `out_ready`=1. Expect `out_imm` 0xFFFFFFFF then 0x0000FFFF, class 01, one per cycle.
- LW 0x8C030000 then ADD 0x00632020. Expect one bubble (`out_valid`=0 for one cycle), `stall_cnt`=1, ADD emitted the next cycle. The same pair with rt=$0 gives no bubble.
- J 0x08000004 at pc 0x10000000. Expect `out_jtarget` 0x10000010, class 10. LUI 0x3C051234 gives `out_imm` 0x12340000.
- `out_ready`=0 for 3 cycles with `out_valid`=1. Expect `in_ready`=0 and fields stable. Release: the next instruction is accepted the same cycle.
- `flush` during a hazard cycle with `out_valid`=1. Expect `out_valid`=0 next cycle, `ld_flag` cleared, no bubble counted, dependent instruction accepted the following cycle.
- Assert `rst` mid-stream with `stall_cnt`=5. Expect all outputs 0 immediately, before the next clock edge.
